// File: rtl/opb_select_stage.sv
// ALU operand-B select stage: source mux, enable gate and subtract inversion,
// registered behind a 2-entry skid buffer with valid/ready on both sides.
module opb_select_stage #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned NUM_SRC = 4,
    parameter int unsigned SEL_W   = $clog2(NUM_SRC)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [NUM_SRC*WIDTH-1:0] src_data,
    input  logic [SEL_W-1:0]         sel,
    input  logic                     inv,
    input  logic                     en,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic                     out_cin,
    output logic                     out_zero
);

    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StOne   = 2'd1,
        StFull  = 2'd2
    } state_e;

    state_e             r_state;
    state_e             w_state_next;
    logic [WIDTH-1:0]   r_out_data;
    logic               r_out_cin;
    logic               r_out_zero;
    logic [WIDTH-1:0]   r_skid_data;
    logic               r_skid_cin;
    logic               r_skid_zero;

    logic [WIDTH-1:0]   w_base;
    logic [WIDTH-1:0]   w_data;
    logic               w_zero;
    logic               w_accept;
    logic               w_pop;
    logic               w_load_out;
    logic               w_load_skid;
    logic               w_move_skid;

    // Select values that match no source (out of range) fall through to zero.
    always_comb begin
        w_base = '0;
        if (en) begin
            for (int k = 0; k < int'(NUM_SRC); k++) begin
                if (sel == SEL_W'(k)) begin
                    w_base = src_data[k*WIDTH +: WIDTH];
                end
            end
        end
    end

    assign w_data = inv ? ~w_base : w_base;
    assign w_zero = (w_data == '0);

    assign out_valid = (r_state != StEmpty);
    assign in_ready  = !rst && (r_state != StFull);
    assign out_data  = r_out_data;
    assign out_cin   = r_out_cin;
    assign out_zero  = r_out_zero;

    assign w_accept = in_valid & in_ready;
    assign w_pop    = out_valid & out_ready;

    always_comb begin
        w_state_next = r_state;
        w_load_out   = 1'b0;
        w_load_skid  = 1'b0;
        w_move_skid  = 1'b0;
        unique case (r_state)
            StEmpty: begin
                if (w_accept) begin
                    w_load_out   = 1'b1;
                    w_state_next = StOne;
                end
            end
            StOne: begin
                if (w_accept && w_pop) begin
                    w_load_out = 1'b1;
                end else if (w_accept) begin
                    w_load_skid  = 1'b1;
                    w_state_next = StFull;
                end else if (w_pop) begin
                    w_state_next = StEmpty;
                end
            end
            StFull: begin
                if (w_pop) begin
                    w_move_skid  = 1'b1;
                    w_state_next = StOne;
                end
            end
            default: w_state_next = StEmpty;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_state     <= StEmpty;
            r_out_data  <= '0;
            r_out_cin   <= 1'b0;
            r_out_zero  <= 1'b0;
            r_skid_data <= '0;
            r_skid_cin  <= 1'b0;
            r_skid_zero <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_load_out) begin
                r_out_data <= w_data;
                r_out_cin  <= inv;
                r_out_zero <= w_zero;
            end else if (w_move_skid) begin
                r_out_data <= r_skid_data;
                r_out_cin  <= r_skid_cin;
                r_out_zero <= r_skid_zero;
            end
            if (w_load_skid) begin
                r_skid_data <= w_data;
                r_skid_cin  <= inv;
                r_skid_zero <= w_zero;
            end
        end
    end

endmodule

// File: doc/opb_select_stage.md
Name: opb_select_stage

Overview:
- Parametrised, pipelined successor to the single-cycle ALU operand-B selector.
- Selects one of NUM_SRC operand sources, optionally inverts it for subtraction, gates it with an enable, and registers the result.
- The registered result sits behind a 2-entry skid buffer with valid/ready handshake on both sides.
- Sits between decode/forwarding and the ALU in the pipelined CPU; carries the subtract carry-in alongside the data.

Parameters:
- WIDTH, 32, operand data width in bits.
- NUM_SRC, 4, number of selectable operand sources (≥2).
- SEL_W, $clog2(NUM_SRC), select field width (derived; do not override).

Ports:
- clk  input  1  sole clock, all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- flush  input  1  synchronous pipeline flush; discards all buffered entries.
- in_valid  input  1  upstream entry valid.
- in_ready  output  1  stage can accept an entry this cycle.
- src_data  input  NUM_SRC*WIDTH  flattened sources; source k occupies bits [k*WIDTH +: WIDTH].
- sel  input  SEL_W  source index.
- inv  input  1  1 = bitwise invert selected source (subtract).
- en  input  1  0 = force selected value to zero, before inversion.
- out_valid  output  1  output entry valid.
- out_ready  input  1  downstream accepts output this cycle.
- out_data  output  WIDTH  registered operand.
- out_cin  output  1  registered carry-in (= inv of the entry).
- out_zero  output  1  registered flag, out_data == 0.

Behaviour:
- Datapath per entry:
  - base = (en && sel < NUM_SRC) ? src[sel] : 0.
  - data = inv ? ~base : base.
  - cin = inv.
  - zero = (data == 0).
- Out-of-range sel behaves as en=0, e.g. sel=5 with NUM_SRC=6 is in range, sel=7 is not; inv still applies.
- Handshake terms: accept = in_valid & in_ready; pop = out_valid & out_ready.
  - Inputs are sampled only on accept.
  - Outputs are held stable while out_valid & !out_ready.
- State machine (2-bit state register), with a main register (OUT) and a skid register (SKID):
  - EMPTY: out_valid=0, in_ready=1. accept → load OUT, go ONE.
  - ONE: out_valid=1, in_ready=1.
    - accept & pop → load OUT with new entry, stay ONE.
    - accept & !pop → load SKID, go FULL.
    - !accept & pop → go EMPTY.
    - neither → hold.
  - FULL: out_valid=1, in_ready=0.
    - pop → OUT ← SKID, go ONE.
    - else hold.
    - No accept is possible in FULL.
- in_ready is a function of the state register only (no combinational path from out_ready).
- Latency: 1 cycle from accept in EMPTY/ONE to out_valid/out_data. Throughput is 1 entry/cycle with out_ready held high.
- Ordering is strict FIFO; no entry is dropped or duplicated.
- flush (priority over accept/pop):
  - Next state EMPTY.
  - OUT/SKID data, cin and zero cleared to 0.
  - An entry presented in the flush cycle is discarded.
  - in_ready stays 1 during flush unless rst is asserted.
- rst (priority over flush):
  - Next state EMPTY.
  - out_valid=0, out_data=0, out_cin=0, out_zero=0 (stored zero flag reset to 0, not 1).
  - in_ready=0 while rst is high; in_ready=1 the cycle after deassertion.
- Reset mid-transfer: any buffered entries are lost; no partial entry is observable afterwards.
- Values are unknown-free after reset; out_data is 0 whenever out_valid=0 after rst/flush. Otherwise out_data holds the last value when invalid.

Test Plan:
- Reset: rst=1 for 2 cycles with in_valid=1 → out_valid=0, out_data=0, out_cin=0, in_ready=0; cycle after release → in_ready=1.
- Select/invert: src[2]=32'h0000_00FF, sel=2, inv=1, en=1, out_ready=1 → next cycle out_data=32'hFFFF_FF00, out_cin=1, out_zero=0.
- Enable/range:
  - en=0, inv=1 → out_data=32'hFFFF_FFFF, out_cin=1.
  - NUM_SRC=3, sel=3, inv=0 → out_data=0, out_zero=1.
- Backpressure/skid: out_ready=0, send A=1, B=2 on consecutive cycles → after B, state FULL, in_ready=0, out_data=1 held. Raise out_ready → 1 then 2 delivered on consecutive cycles, then out_valid=0.
- Streaming: out_ready=1, 8 back-to-back entries 10..17 → 8 consecutive outputs 10..17 in order, in_ready never drops.
- Flush: state FULL (A=5 in OUT, B=6 in SKID), flush=1 with in_valid=1, C=7 → next cycle out_valid=0, out_data=0, in_ready=1; C never appears.
